apu_dispatch_queue: RTL and testbench

Parametrised APU front end for the vector accelerator. It accepts CV32E40P-style APU requests into a DEPTH-entry in-order queue and issues them one at a time to the vector decoder with a valid/ready handshake. Completions may return out of order by tag; a reorder store holds them until they can retire. The block returns formatted scalar results to the core strictly in request order, one `apu_rvalid_o` pulse per granted request.

---
 rtl/accelerator_pkg.sv | 50 +++++
 rtl/apu_dispatch_queue.sv | 125 ++++++++++++
 tb/tb_apu_dispatch_queue.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_pkg.sv
// Shared types for the vector accelerator APU front end:
// slot record, completion result source and result formatting.
package accelerator_pkg;

    // Slot widths; the dispatch queue parameters default to these.
    localparam int APU_XLEN    = 32;
    localparam int APU_ELEN    = 32;
    localparam int APU_OP_W    = 6;
    localparam int APU_FLAGS_W = 15;

    typedef enum logic [1:0] {
        APU_RESULT_SRC_VL    = 2'd0,
        APU_RESULT_SRC_VS2_0 = 2'd1,
        APU_RESULT_SRC_NONE  = 2'd2
    } apu_result_src_t;

    localparam logic APU_DONE_NONE = 1'b0;

    typedef struct packed {
        logic [2:0][APU_XLEN-1:0] operands;
        logic [APU_OP_W-1:0]      op;
        logic [APU_FLAGS_W-1:0]   flags;
        logic [APU_XLEN-1:0]      result;
        logic                     done;
    } apu_slot_t;

    function automatic logic [APU_XLEN-1:0] apu_format_result(
        input apu_result_src_t     src,
        input logic [7:0]          vl,
        input logic [APU_ELEN-1:0] elem,
        input logic [1:0]          vsew
    );
        logic [APU_XLEN-1:0] res;
        res = '0;
        unique case (src)
            APU_RESULT_SRC_VL: res = APU_XLEN'(vl);
            APU_RESULT_SRC_VS2_0: begin
                unique case (vsew)
                    2'd0: res = APU_XLEN'({{56{elem[7]}}, elem[7:0]});
                    2'd1: res = APU_XLEN'({{48{elem[15]}}, elem[15:0]});
                    2'd2: res = APU_XLEN'({{32{elem[31]}}, elem[31:0]});
                    default: res = (APU_ELEN == 64) ? APU_XLEN'(64'(elem)) : '0;
                endcase
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/apu_dispatch_queue.sv
// In-order APU request queue with out-of-order completion
// reorder store; results retire to the core in request order.
module apu_dispatch_queue
    import accelerator_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XLEN    = APU_XLEN,
    parameter int ELEN    = APU_ELEN,
    parameter int OP_W    = APU_OP_W,
    parameter int FLAGS_W = APU_FLAGS_W,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     apu_req_i,
    output logic                     apu_gnt_o,
    input  logic [2:0][XLEN-1:0]     apu_operands_i,
    input  logic [OP_W-1:0]          apu_op_i,
    input  logic [FLAGS_W-1:0]       apu_flags_i,
    output logic                     apu_rvalid_o,
    output logic [XLEN-1:0]          apu_result_o,
    output logic [4:0]               apu_flags_o,
    output logic                     iss_valid_o,
    input  logic                     iss_ready_i,
    output logic [2:0][XLEN-1:0]     iss_operands_o,
    output logic [OP_W-1:0]          iss_op_o,
    output logic [FLAGS_W-1:0]       iss_flags_o,
    output logic [TAG_W-1:0]         iss_tag_o,
    input  logic                     cmp_valid_i,
    input  logic [TAG_W-1:0]         cmp_tag_i,
    input  apu_result_src_t          cmp_src_i,
    input  logic [7:0]               cmp_vl_i,
    input  logic [ELEN-1:0]          cmp_elem_i,
    input  logic [1:0]               cmp_vsew_i,
    output logic [TAG_W:0]           count_o,
    output logic                     protocol_err_o
);

    localparam int PTR_W = TAG_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] alloc_q, alloc_d;
    logic [PTR_W-1:0] issue_q, issue_d;
    logic [PTR_W-1:0] retire_q, retire_d;
    apu_slot_t        slot_q [DEPTH];
    apu_slot_t        slot_d [DEPTH];
    logic             rvalid_q, rvalid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             err_q, err_d;

    logic [TAG_W-1:0] alloc_idx, issue_idx, retire_idx;
    logic [PTR_W-1:0] in_flight, cmp_off;
    logic             do_issue, cmp_ok, do_retire;

    assign alloc_idx  = alloc_q[TAG_W-1:0];
    assign issue_idx  = issue_q[TAG_W-1:0];
    assign retire_idx = retire_q[TAG_W-1:0];

    assign count_o     = alloc_q - retire_q;
    assign apu_gnt_o   = apu_req_i & (count_o < DEPTH_P) & ~reset;
    assign iss_valid_o = (issue_q != alloc_q);
    assign do_issue    = iss_valid_o & iss_ready_i;

    // Tag must sit in [retire, issue) of the pre-cycle pointers,
    // which also guarantees it was issued in an earlier cycle.
    assign in_flight = issue_q - retire_q;
    assign cmp_off   = {1'b0, cmp_tag_i - retire_idx};
    assign cmp_ok    = cmp_valid_i & (cmp_off < in_flight)
                     & (slot_q[cmp_tag_i].done == APU_DONE_NONE);
    assign do_retire = (retire_q != issue_q) & slot_q[retire_idx].done;

    assign iss_operands_o = slot_q[issue_idx].operands;
    assign iss_op_o       = slot_q[issue_idx].op;
    assign iss_flags_o    = slot_q[issue_idx].flags;
    assign iss_tag_o      = issue_idx;

    assign apu_rvalid_o   = rvalid_q;
    assign apu_result_o   = result_q;
    assign apu_flags_o    = '0;
    assign protocol_err_o = err_q;

    always_comb begin
        slot_d   = slot_q;
        alloc_d  = alloc_q + PTR_W'(apu_gnt_o);
        issue_d  = issue_q + PTR_W'(do_issue);
        retire_d = retire_q + PTR_W'(do_retire);
        if (apu_gnt_o) begin
            slot_d[alloc_idx].operands = apu_operands_i;
            slot_d[alloc_idx].op       = apu_op_i;
            slot_d[alloc_idx].flags    = apu_flags_i;
        end
        if (cmp_ok) begin
            slot_d[cmp_tag_i].result = apu_format_result(
                cmp_src_i, cmp_vl_i, cmp_elem_i, cmp_vsew_i);
            slot_d[cmp_tag_i].done   = 1'b1;
        end
        if (do_retire) begin
            slot_d[retire_idx].done = APU_DONE_NONE;
        end
        rvalid_d = do_retire;
        result_d = do_retire ? slot_q[retire_idx].result : result_q;
        err_d    = err_q | (cmp_valid_i & ~cmp_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_q  <= '0;
            issue_q  <= '0;
            retire_q <= '0;
            slot_q   <= '{default: '0};
            rvalid_q <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            alloc_q  <= alloc_d;
            issue_q  <= issue_d;
            retire_q <= retire_d;
            slot_q   <= slot_d;
            rvalid_q <= rvalid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_apu_dispatch_queue.sv
// Bench for apu_dispatch_queue: formatting vectors, hand-written
// corner sequences and a randomized run against a list-based model.
module tb_apu_dispatch_queue;
    import accelerator_pkg::*;

    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam int ELEN    = 32;
    localparam int OP_W    = 6;
    localparam int FLAGS_W = 15;
    localparam int TAG_W   = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 apu_req_i;
    logic                 apu_gnt_o;
    logic [2:0][XLEN-1:0] apu_operands_i;
    logic [OP_W-1:0]      apu_op_i;
    logic [FLAGS_W-1:0]   apu_flags_i;
    logic                 apu_rvalid_o;
    logic [XLEN-1:0]      apu_result_o;
    logic [4:0]           apu_flags_o;
    logic                 iss_valid_o;
    logic                 iss_ready_i;
    logic [2:0][XLEN-1:0] iss_operands_o;
    logic [OP_W-1:0]      iss_op_o;
    logic [FLAGS_W-1:0]   iss_flags_o;
    logic [TAG_W-1:0]     iss_tag_o;
    logic                 cmp_valid_i;
    logic [TAG_W-1:0]     cmp_tag_i;
    apu_result_src_t      cmp_src_i;
    logic [7:0]           cmp_vl_i;
    logic [ELEN-1:0]      cmp_elem_i;
    logic [1:0]           cmp_vsew_i;
    logic [TAG_W:0]       count_o;
    logic                 protocol_err_o;

    apu_dispatch_queue #(
        .DEPTH(DEPTH), .XLEN(XLEN), .ELEN(ELEN),
        .OP_W(OP_W), .FLAGS_W(FLAGS_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i),
        .apu_flags_i(apu_flags_i), .apu_rvalid_o(apu_rvalid_o),
        .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_operands_o(iss_operands_o), .iss_op_o(iss_op_o),
        .iss_flags_o(iss_flags_o), .iss_tag_o(iss_tag_o),
        .cmp_valid_i(cmp_valid_i), .cmp_tag_i(cmp_tag_i),
        .cmp_src_i(cmp_src_i), .cmp_vl_i(cmp_vl_i),
        .cmp_elem_i(cmp_elem_i), .cmp_vsew_i(cmp_vsew_i),
        .count_o(count_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apu_req_i      = 1'b0;
        apu_operands_i = '0;
        apu_op_i       = '0;
        apu_flags_i    = '0;
        iss_ready_i    = 1'b0;
        cmp_valid_i    = 1'b0;
        cmp_tag_i      = '0;
        cmp_src_i      = APU_RESULT_SRC_NONE;
        cmp_vl_i       = '0;
        cmp_elem_i     = '0;
        cmp_vsew_i     = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_err", 64'(protocol_err_o), 64'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_req();
        apu_req_i      = 1'b1;
        apu_operands_i = {$urandom, $urandom, $urandom};
        apu_op_i       = OP_W'($urandom);
        apu_flags_i    = FLAGS_W'($urandom);
    endtask

    task automatic drive_cmp(input logic [TAG_W-1:0] tag,
                             input apu_result_src_t src,
                             input logic [7:0] vl,
                             input logic [31:0] elem,
                             input logic [1:0] vsew);
        cmp_valid_i = 1'b1;
        cmp_tag_i   = tag;
        cmp_src_i   = src;
        cmp_vl_i    = vl;
        cmp_elem_i  = elem;
        cmp_vsew_i  = vsew;
    endtask

    // Element width is 8 << vsew; wider than ELEN yields 0.
    function automatic logic [31:0] ref_fmt(input apu_result_src_t src,
                                            input logic [7:0] vl,
                                            input logic [31:0] elem,
                                            input logic [1:0] vsew);
        int w;
        logic signed [31:0] s;
        if (src == APU_RESULT_SRC_VL) return {24'd0, vl};
        if (src != APU_RESULT_SRC_VS2_0) return '0;
        w = 8 << vsew;
        if (w > ELEN) return '0;
        if (w >= 32) return elem;
        s = elem << (32 - w);
        return s >>> (32 - w);
    endfunction

    typedef struct {
        apu_result_src_t src;
        logic [7:0]      vl;
        logic [31:0]     elem;
        logic [1:0]      vsew;
        logic [31:0]     exp;
    } vec_t;

    typedef struct {
        logic [TAG_W-1:0]     tag;
        logic [2:0][XLEN-1:0] ops;
        logic [OP_W-1:0]      op;
        logic                 issued;
        logic                 done;
        logic [31:0]          result;
    } ent_t;

    vec_t vecs[10];
    ent_t q[$];

    initial begin
        vecs[0] = '{APU_RESULT_SRC_VL,    8'd16,  32'h0,        2'd0, 32'h10};
        vecs[1] = '{APU_RESULT_SRC_VS2_0, 8'd0,   32'h000000A1, 2'd0, 32'hFFFFFFA1};
        vecs[2] = '{APU_RESULT_SRC_VS2_0, 8'd0,   32'h00008001, 2'd1, 32'hFFFF8001};
        vecs[3] = '{APU_RESULT_SRC_VS2_0, 8'd3,   32'h80000001, 2'd3, 32'h0};
        vecs[4] = '{APU_RESULT_SRC_VS2_0, 8'd0,   32'h1234807F, 2'd0, 32'h7F};
        vecs[5] = '{APU_RESULT_SRC_VS2_0, 8'd0,   32'hABCD8000, 2'd1, 32'hFFFF8000};
        vecs[6] = '{APU_RESULT_SRC_VS2_0, 8'd0,   32'h89ABCDEF, 2'd2, 32'h89ABCDEF};
        vecs[7] = '{APU_RESULT_SRC_NONE,  8'd5,   32'hFFFFFFFF, 2'd0, 32'h0};
        vecs[8] = '{APU_RESULT_SRC_VL,    8'd255, 32'hFFFFFFFF, 2'd2, 32'hFF};
        vecs[9] = '{APU_RESULT_SRC_VS2_0, 8'd0,   32'h00007FFF, 2'd1, 32'h7FFF};

        idle();
        apu_req_i = 1'b1;
        #2;
        chk("rst_gnt", 64'(apu_gnt_o), 64'd0);
        chk("rst_rvalid", 64'(apu_rvalid_o), 64'd0);
        chk("rst_result", 64'(apu_result_o), 64'd0);
        chk("rst_iss_valid", 64'(iss_valid_o), 64'd0);
        chk("rst_count0", 64'(count_o), 64'd0);
        chk("rst_flags", 64'(apu_flags_o), 64'd0);
        tick();
        reset = 1'b0;
        apu_req_i = 1'b0;

        // formatting vectors, one request each through the full latency
        for (int i = 0; i < 10; i++) begin
            logic [31:0] op0;
            drive_req();
            op0 = apu_operands_i[0];
            #1;
            chk("vec_gnt", 64'(apu_gnt_o), 64'd1);
            tick();
            apu_req_i = 1'b0;
            iss_ready_i = 1'b1;
            #1;
            chk("vec_iss_valid", 64'(iss_valid_o), 64'd1);
            chk("vec_iss_tag", 64'(iss_tag_o), 64'(i % DEPTH));
            chk("vec_iss_op0", 64'(iss_operands_o[0]), 64'(op0));
            tick();
            iss_ready_i = 1'b0;
            drive_cmp(TAG_W'(i % DEPTH), vecs[i].src, vecs[i].vl,
                      vecs[i].elem, vecs[i].vsew);
            tick();
            cmp_valid_i = 1'b0;
            #1;
            chk("vec_rvalid_early", 64'(apu_rvalid_o), 64'd0);
            tick();
            chk("vec_rvalid", 64'(apu_rvalid_o), 64'd1);
            chk("vec_result", 64'(apu_result_o), 64'(vecs[i].exp));
            chk("vec_count", 64'(count_o), 64'd0);
            tick();
            chk("vec_rvalid_pulse", 64'(apu_rvalid_o), 64'd0);
            chk("vec_result_hold", 64'(apu_result_o), 64'(vecs[i].exp));
        end

        // full queue; a retire frees a slot only for the following cycle
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive_req();
            #1;
            chk("full_gnt", 64'(apu_gnt_o), 64'd1);
            chk("full_count", 64'(count_o), 64'(k));
            tick();
        end
        iss_ready_i = 1'b1;
        #1;
        chk("full_nogrant", 64'(apu_gnt_o), 64'd0);
        chk("full_count4", 64'(count_o), 64'd4);
        tick();
        iss_ready_i = 1'b0;
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'd9, 32'h0, 2'd0);
        #1;
        chk("full_nogrant_cmp", 64'(apu_gnt_o), 64'd0);
        tick();
        cmp_valid_i = 1'b0;
        #1;
        chk("full_nogrant_retire", 64'(apu_gnt_o), 64'd0);
        tick();
        chk("full_rvalid", 64'(apu_rvalid_o), 64'd1);
        chk("full_result", 64'(apu_result_o), 64'd9);
        chk("full_count3", 64'(count_o), 64'd3);
        chk("full_regrant", 64'(apu_gnt_o), 64'd1);
        tick();
        apu_req_i = 1'b0;
        #1;
        chk("full_count_back", 64'(count_o), 64'd4);

        // out-of-order completion, in-order retire
        do_reset();
        iss_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_req();
            tick();
        end
        apu_req_i = 1'b0;
        tick();
        iss_ready_i = 1'b0;
        drive_cmp(2'd2, APU_RESULT_SRC_VS2_0, 8'd0, 32'hC3, 2'd0);
        tick();
        drive_cmp(2'd0, APU_RESULT_SRC_VS2_0, 8'd0, 32'hA1, 2'd0);
        tick();
        drive_cmp(2'd1, APU_RESULT_SRC_VS2_0, 8'd0, 32'hB2, 2'd0);
        #1;
        chk("ooo_wait", 64'(apu_rvalid_o), 64'd0);
        tick();
        cmp_valid_i = 1'b0;
        #1;
        chk("ooo_rv0", 64'(apu_rvalid_o), 64'd1);
        chk("ooo_res0", 64'(apu_result_o), 64'hFFFFFFA1);
        tick();
        chk("ooo_rv1", 64'(apu_rvalid_o), 64'd1);
        chk("ooo_res1", 64'(apu_result_o), 64'hFFFFFFB2);
        tick();
        chk("ooo_rv2", 64'(apu_rvalid_o), 64'd1);
        chk("ooo_res2", 64'(apu_result_o), 64'hFFFFFFC3);
        chk("ooo_count", 64'(count_o), 64'd0);
        chk("ooo_err", 64'(protocol_err_o), 64'd0);
        tick();
        chk("ooo_rv_end", 64'(apu_rvalid_o), 64'd0);

        // completion for a granted but unissued tag
        do_reset();
        drive_req();
        tick();
        apu_req_i = 1'b0;
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'd1, 32'h0, 2'd0);
        tick();
        cmp_valid_i = 1'b0;
        #1;
        chk("perr_unissued", 64'(protocol_err_o), 64'd1);
        chk("perr_unissued_count", 64'(count_o), 64'd1);
        tick();
        chk("perr_unissued_norv", 64'(apu_rvalid_o), 64'd0);
        chk("perr_sticky", 64'(protocol_err_o), 64'd1);
        do_reset();
        #1;
        chk("perr_cleared", 64'(protocol_err_o), 64'd0);

        // completion in the same cycle as the issue
        drive_req();
        tick();
        apu_req_i = 1'b0;
        iss_ready_i = 1'b1;
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'd1, 32'h0, 2'd0);
        tick();
        iss_ready_i = 1'b0;
        cmp_valid_i = 1'b0;
        #1;
        chk("perr_same_cycle", 64'(protocol_err_o), 64'd1);

        // duplicate completion: one retire only
        do_reset();
        drive_req();
        tick();
        apu_req_i = 1'b0;
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'd33, 32'h0, 2'd0);
        tick();
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'd44, 32'h0, 2'd0);
        #1;
        chk("dup_err_before", 64'(protocol_err_o), 64'd0);
        tick();
        cmp_valid_i = 1'b0;
        #1;
        chk("dup_err", 64'(protocol_err_o), 64'd1);
        chk("dup_rvalid", 64'(apu_rvalid_o), 64'd1);
        chk("dup_result", 64'(apu_result_o), 64'd33);
        tick();
        chk("dup_no_second", 64'(apu_rvalid_o), 64'd0);
        chk("dup_count", 64'(count_o), 64'd0);

        // reset with three requests in flight
        do_reset();
        iss_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_req();
            tick();
        end
        apu_req_i = 1'b0;
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'd7, 32'h0, 2'd0);
        tick();
        idle();
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count_o), 64'd0);
        chk("mid_rst_rvalid", 64'(apu_rvalid_o), 64'd0);
        chk("mid_rst_iss", 64'(iss_valid_o), 64'd0);
        tick();
        chk("mid_rst_rvalid2", 64'(apu_rvalid_o), 64'd0);
        reset = 1'b0;
        tick();
        drive_req();
        #1;
        chk("post_rst_gnt", 64'(apu_gnt_o), 64'd1);
        tick();
        apu_req_i = 1'b0;
        iss_ready_i = 1'b1;
        #1;
        chk("post_rst_tag", 64'(iss_tag_o), 64'd0);
        tick();
        iss_ready_i = 1'b0;
        drive_cmp(2'd0, APU_RESULT_SRC_VL, 8'h21, 32'h0, 2'd0);
        tick();
        cmp_valid_i = 1'b0;
        #1;
        chk("post_rst_norv", 64'(apu_rvalid_o), 64'd0);
        tick();
        chk("post_rst_rvalid", 64'(apu_rvalid_o), 64'd1);
        chk("post_rst_result", 64'(apu_result_o), 64'h21);

        // randomized traffic against a list-of-requests model
        do_reset();
        begin
            logic        exp_rv;
            logic [31:0] exp_res;
            int          n_iss;
            int          seq;
            exp_rv  = 1'b0;
            exp_res = 32'h21;
            n_iss   = 0;
            seq     = 0;
            q.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                int   cands[$];
                int   ci;
                logic exp_gnt, exp_iv, retire_now;
                ent_t e;
                idle();
                if ($urandom_range(0, 2) != 0) drive_req();
                iss_ready_i = 1'($urandom_range(0, 1));
                cands.delete();
                for (int j = 0; j < q.size(); j++)
                    if (q[j].issued && !q[j].done) cands.push_back(j);
                ci = -1;
                if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
                    ci = cands[$urandom_range(0, cands.size() - 1)];
                    drive_cmp(q[ci].tag,
                              apu_result_src_t'($urandom_range(0, 2)),
                              8'($urandom), $urandom,
                              2'($urandom_range(0, 3)));
                end
                #1;
                exp_gnt = apu_req_i && (q.size() < DEPTH);
                exp_iv  = (n_iss < q.size());
                chk("rnd_gnt", 64'(apu_gnt_o), 64'(exp_gnt));
                chk("rnd_count", 64'(count_o), 64'(q.size()));
                chk("rnd_iss_valid", 64'(iss_valid_o), 64'(exp_iv));
                if (exp_iv) begin
                    chk("rnd_iss_tag", 64'(iss_tag_o), 64'(q[n_iss].tag));
                    chk("rnd_iss_op2", 64'(iss_operands_o[2]),
                        64'(q[n_iss].ops[2]));
                    chk("rnd_iss_op", 64'(iss_op_o), 64'(q[n_iss].op));
                end
                chk("rnd_rvalid", 64'(apu_rvalid_o), 64'(exp_rv));
                if (exp_rv)
                    chk("rnd_result", 64'(apu_result_o), 64'(exp_res));

                retire_now = (q.size() > 0) && q[0].done;
                exp_rv = retire_now;
                if (retire_now) exp_res = q[0].result;
                if (ci >= 0) begin
                    q[ci].done   = 1'b1;
                    q[ci].result = ref_fmt(cmp_src_i, cmp_vl_i,
                                           cmp_elem_i, cmp_vsew_i);
                end
                if (exp_iv && iss_ready_i) begin
                    q[n_iss].issued = 1'b1;
                    n_iss++;
                end
                if (retire_now) begin
                    void'(q.pop_front());
                    n_iss--;
                end
                if (exp_gnt) begin
                    e.tag    = TAG_W'(seq % DEPTH);
                    e.ops    = apu_operands_i;
                    e.op     = apu_op_i;
                    e.issued = 1'b0;
                    e.done   = 1'b0;
                    e.result = '0;
                    q.push_back(e);
                    seq++;
                end
                tick();
            end
        end
        chk("rnd_no_err", 64'(protocol_err_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
